// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator (640x480@60 defaults).
package vga_timing_pkg;

  localparam int unsigned CNT_W          = 10;
  localparam int unsigned CNT_MAX_TOTAL  = 1024;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  typedef logic [CNT_W-1:0] coord_t;

  typedef struct packed {
    logic   hs;
    logic   vs;
    logic   display;
    coord_t ox;
    coord_t oy;
    logic   frame_start;
    logic   line_start;
  } vga_out_t;

  // Pin level for a sync signal given whether it is in its active window.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle delivered to the pixel colour stage.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   VGA_HS;
  logic   VGA_VS;
  logic   display;
  coord_t oX;
  coord_t oY;
  logic   frame_start;
  logic   line_start;

  modport master (output VGA_HS, VGA_VS, display, oX, oY, frame_start, line_start);
  modport slave  (input  VGA_HS, VGA_VS, display, oX, oY, frame_start, line_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus visible/sync window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t cnt,
  output logic   wrap,
  output logic   active,
  output logic   sync_active
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

  coord_t cnt_q, cnt_d;

  always_comb begin
    wrap        = inc && (32'(cnt_q) == TOTAL - 1);
    cnt_d       = cnt_q;
    if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    active      = 32'(cnt_q) < ACTIVE;
    sync_active = (32'(cnt_q) >= SYNC_START) && (32'(cnt_q) < SYNC_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a single aligned output register stage.
// Optional pixel clock-enable input when VGA_TIMING_CE_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          H_POL    = POL_ACTIVE_LOW,
  parameter bit          V_POL    = POL_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef VGA_TIMING_CE_EN
  input  logic               pix_ce,
`endif
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end

  localparam vga_out_t OUT_RST = '{hs: ~H_POL, vs: ~V_POL, display: 1'b0, ox: '0, oy: '0,
                                   frame_start: 1'b0, line_start: 1'b0};

  logic   adv;
  coord_t h_cnt, v_cnt;
  logic   h_wrap, h_active, h_sync;
  logic   v_wrap, v_active, v_sync;
  logic   vis_c;
  vga_out_t out_q, out_d;

`ifdef VGA_TIMING_CE_EN
  assign adv = pix_ce;
`else
  assign adv = 1'b1;
`endif

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
    .clk(clk), .rst_n(rst_n), .inc(adv),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync_active(h_sync)
  );

  // Vertical axis steps once per completed line.
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
    .clk(clk), .rst_n(rst_n), .inc(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_active), .sync_active(v_sync)
  );

  // Start pulses drop on non-advancing edges; everything else holds.
  always_comb begin
    vis_c             = h_active && v_active;
    out_d             = out_q;
    out_d.frame_start = 1'b0;
    out_d.line_start  = 1'b0;
    if (adv) begin
      out_d.display     = vis_c;
      out_d.ox          = vis_c ? h_cnt : '0;
      out_d.oy          = vis_c ? v_cnt : '0;
      out_d.hs          = sync_level(h_sync, H_POL);
      out_d.vs          = sync_level(v_sync, V_POL);
      out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
      out_d.line_start  = (h_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= OUT_RST;
    else        out_q <= out_d;
  end

  frame_wrap_chk: assert property (@(posedge clk) disable iff (!rst_n) v_wrap |-> h_wrap);

  assign vga.VGA_HS      = out_q.hs;
  assign vga.VGA_VS      = out_q.vs;
  assign vga.display     = out_q.display;
  assign vga.oX          = out_q.ox;
  assign vga.oY          = out_q.oy;
  assign vga.frame_start = out_q.frame_start;
  assign vga.line_start  = out_q.line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny inverted-polarity instance.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef VGA_TIMING_CE_EN
  logic pix_ce = 1'b1;
`endif

  always #5 clk = ~clk;

  vga_timing_gen_if v0();
  vga_timing_gen_if v1();

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce),
`endif
    .vga(v0)
  );

  // Tiny raster: 16 x 8 total, active-high syncs.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce),
`endif
    .vga(v1)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int edge_no; int sel;
    int hs; int vs; int disp; int ox; int oy; int fs; int ls;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(int e, int s, int hs, int vs, int d, int x, int y, int fs, int ls);
    vec_t v;
    v.edge_no = e; v.sel = s; v.hs = hs; v.vs = vs; v.disp = d;
    v.ox = x; v.oy = y; v.fs = fs; v.ls = ls;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string p, input int sel, input int hs, input int vs,
                            input int d, input int x, input int y, input int fs, input int ls);
    if (sel == 0) begin
      chk({p, "_hs"}, int'(v0.VGA_HS), hs);       chk({p, "_vs"}, int'(v0.VGA_VS), vs);
      chk({p, "_disp"}, int'(v0.display), d);     chk({p, "_ox"}, int'(v0.oX), x);
      chk({p, "_oy"}, int'(v0.oY), y);            chk({p, "_fs"}, int'(v0.frame_start), fs);
      chk({p, "_ls"}, int'(v0.line_start), ls);
    end else begin
      chk({p, "_hs"}, int'(v1.VGA_HS), hs);       chk({p, "_vs"}, int'(v1.VGA_VS), vs);
      chk({p, "_disp"}, int'(v1.display), d);     chk({p, "_ox"}, int'(v1.oX), x);
      chk({p, "_oy"}, int'(v1.oY), y);            chk({p, "_fs"}, int'(v1.frame_start), fs);
      chk({p, "_ls"}, int'(v1.line_start), ls);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  // Run-length / period statistics gathered from negedge samples after release.
  int cyc, hs_lo, hs_run0, hs_first0, ls_last, ls_per0, ls_run, ls_wmax, disp_acc, disp_line0, mx0;
  int vs_hi, vs_run1, vs_first1, hs_hi1, hs_run1, hs_first1, fs_last, fs_per1, dacc1, dframe1, mx1, my1;

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0; hs_lo = 0; hs_run0 = -1; hs_first0 = -1; ls_last = -1; ls_per0 = -1;
      ls_run = 0; ls_wmax = 0; disp_acc = 0; disp_line0 = -1; mx0 = 0;
      vs_hi = 0; vs_run1 = -1; vs_first1 = -1; hs_hi1 = 0; hs_run1 = -1; hs_first1 = -1;
      fs_last = -1; fs_per1 = -1; dacc1 = 0; dframe1 = -1; mx1 = 0; my1 = 0;
    end else begin
      cyc++;
      if (!v0.VGA_HS) begin
        if (hs_first0 < 0) hs_first0 = cyc;
        hs_lo++;
      end else begin
        if (hs_lo > 0 && hs_run0 < 0) hs_run0 = hs_lo;
        hs_lo = 0;
      end
      if (v0.line_start) begin
        if (ls_last >= 0) begin
          if (ls_per0 < 0) ls_per0 = cyc - ls_last;
          if (disp_line0 < 0) disp_line0 = disp_acc;
        end
        ls_last = cyc; disp_acc = 0; ls_run++;
        if (ls_run > ls_wmax) ls_wmax = ls_run;
      end else begin
        ls_run = 0;
      end
      if (v0.display) begin
        disp_acc++;
        if (int'(v0.oX) > mx0) mx0 = int'(v0.oX);
      end

      if (v1.VGA_VS) begin
        if (vs_first1 < 0) vs_first1 = cyc;
        vs_hi++;
      end else begin
        if (vs_hi > 0 && vs_run1 < 0) vs_run1 = vs_hi;
        vs_hi = 0;
      end
      if (v1.VGA_HS) begin
        if (hs_first1 < 0) hs_first1 = cyc;
        hs_hi1++;
      end else begin
        if (hs_hi1 > 0 && hs_run1 < 0) hs_run1 = hs_hi1;
        hs_hi1 = 0;
      end
      if (v1.frame_start) begin
        if (fs_last >= 0) begin
          if (fs_per1 < 0) fs_per1 = cyc - fs_last;
          if (dframe1 < 0) dframe1 = dacc1;
        end
        fs_last = cyc; dacc1 = 0;
      end
      if (v1.display) begin
        dacc1++;
        if (int'(v1.oX) > mx1) mx1 = int'(v1.oX);
        if (int'(v1.oY) > my1) my1 = int'(v1.oY);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // edge, dut, hs, vs, display, oX, oY, frame_start, line_start
    add(1,     0, 1, 1, 1,   0,   0, 1, 1);
    add(1,     1, 0, 0, 1,   0,   0, 1, 1);
    add(2,     0, 1, 1, 1,   1,   0, 0, 0);
    add(11,    1, 1, 0, 0,   0,   0, 0, 0);
    add(13,    1, 1, 0, 0,   0,   0, 0, 0);
    add(14,    1, 0, 0, 0,   0,   0, 0, 0);
    add(52,    1, 0, 0, 1,   3,   3, 0, 0);
    add(57,    1, 0, 0, 0,   0,   0, 0, 0);
    add(81,    1, 0, 1, 0,   0,   0, 0, 1);
    add(113,   1, 0, 0, 0,   0,   0, 0, 1);
    add(129,   1, 0, 0, 1,   0,   0, 1, 1);
    add(640,   0, 1, 1, 1, 639,   0, 0, 0);
    add(641,   0, 1, 1, 0,   0,   0, 0, 0);
    add(656,   0, 1, 1, 0,   0,   0, 0, 0);
    add(657,   0, 0, 1, 0,   0,   0, 0, 0);
    add(752,   0, 0, 1, 0,   0,   0, 0, 0);
    add(753,   0, 1, 1, 0,   0,   0, 0, 0);
    add(800,   0, 1, 1, 0,   0,   0, 0, 0);
    add(801,   0, 1, 1, 1,   0,   1, 0, 1);
    add(802,   0, 1, 1, 1,   1,   1, 0, 0);
    add(80701, 0, 0, 1, 0,   0,   0, 0, 0);

    // Power-on reset held across edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("por0", 0, 1, 1, 0, 0, 0, 0, 0);
    check_outs("por1", 1, 0, 0, 0, 0, 0, 0, 0);

    #1; rst_n = 1'b1; mon_en = 1'b1; edge_cnt = 0;
    foreach (vecs[i]) begin
      while (edge_cnt < vecs[i].edge_no) step();
      check_outs($sformatf("e%0d_d%0d", vecs[i].edge_no, vecs[i].sel), vecs[i].sel,
                 vecs[i].hs, vecs[i].vs, vecs[i].disp, vecs[i].ox, vecs[i].oy,
                 vecs[i].fs, vecs[i].ls);
    end

    chk("hs0_first_low", hs_first0, 657);
    chk("hs0_low_width", hs_run0, 96);
    chk("ls0_period", ls_per0, 800);
    chk("ls0_width", ls_wmax, 1);
    chk("disp0_per_line", disp_line0, 640);
    chk("ox0_max", mx0, 639);
    chk("hs1_first_high", hs_first1, 11);
    chk("hs1_high_width", hs_run1, 3);
    chk("vs1_first_high", vs_first1, 81);
    chk("vs1_high_width", vs_run1, 32);
    chk("fs1_period", fs_per1, 128);
    chk("disp1_per_frame", dframe1, 32);
    chk("ox1_max", mx1, 7);
    chk("oy1_max", my1, 3);

    // Mid-run reset: outputs must fall to reset levels without a clock edge.
    mon_en = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    check_outs("rst_async0", 0, 1, 1, 0, 0, 0, 0, 0);
    check_outs("rst_async1", 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1; rst_n = 1'b1; edge_cnt = 0;
    step();
    check_outs("rel_e1_d0", 0, 1, 1, 1, 0, 0, 1, 1);
    check_outs("rel_e1_d1", 1, 0, 0, 1, 0, 0, 1, 1);
    step();
    check_outs("rel_e2_d0", 0, 1, 1, 1, 1, 0, 0, 0);

`ifdef VGA_TIMING_CE_EN
    // Half-rate enable: everything stretches by two clocks per pixel.
    #1; rst_n = 1'b0;
    repeat (2) step();
    #1; rst_n = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 3400; i++) begin
      step();
      pix_ce = ~pix_ce;
    end
    chk("ce_ls_period", ls_per0, 1600);
    chk("ce_hs_low_width", hs_run0, 192);
    chk("ce_ls_width", ls_wmax, 1);
    chk("ce_disp_per_line", disp_line0, 1280);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
